uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, the receive FSM state type and
// the oversampling divider helper used by both link stages.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT  = 100_000_000;
  localparam int unsigned BAUD_RATE_DEFAULT = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Clocks per oversampling tick; integer division, 651 at the defaults.
  function automatic int unsigned calc_tick_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate,
                                                input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-clock tick every TICK_DIV clocks, with a
// synchronous restart that holds the phase at zero while asserted.
module uart_baud_tick #(
  parameter int unsigned TICK_DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, mid-bit sampled 8N1 framing with stop-bit
// error reporting. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = BAUD_RATE_DEFAULT,
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy,
  output rx_state_e             dbg_state
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] HIST0     = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] HIST1     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] SAMPLE_AT = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] SAMPLE_AT = TW'(OVERSAMPLE / 2 - 1);
`endif

  rx_state_e       state, next_state;
  logic            rx_meta, rx_s;
  logic            restart, tick, sample_pt, sample_bit;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Holding the divider in restart while idle aligns every bit to the start edge.
  assign restart = (state == IDLE);

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (restart) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    end
  end

  assign sample_pt = tick && (tick_cnt == SAMPLE_AT);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (tick) begin
      if (tick_cnt == HIST0) hist[0] <= rx_s;
      if (tick_cnt == HIST1) hist[1] <= rx_s;
    end
  end

  assign sample_bit = (hist[0] & hist[1]) | (hist[0] & rx_s) | (hist[1] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (sample_pt) next_state = sample_bit ? IDLE : DATA;
      DATA:    if (sample_pt && bit_cnt == BIT_LAST) next_state = STOP;
      STOP:    if (sample_pt) next_state = sample_bit ? IDLE : BREAK;
      BREAK:   if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // data_valid / frame_err: one-clock strobes with no backpressure; data_out
  // holds its value until the next correctly framed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample_pt) begin
        case (state)
          START: bit_cnt <= '0;
          DATA: begin
            shreg   <= {sample_bit, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          STOP: begin
            if (sample_bit) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced line rate (32 clocks per bit) with
// hand-computed expectations and a scoreboard of expected words.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned DW       = 8;
  localparam int unsigned CLK_FREQ = 3_200_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned OS       = 16;
  localparam int          TICK_DIV = 2;              // 3.2 MHz / (100 kbaud * 16)
  localparam int          BIT      = OS * TICK_DIV;  // 32 clocks per bit
`ifdef UART_RX_MAJORITY_EN
  localparam int          EXP_LAT    = 307 + TICK_DIV;
  localparam logic [7:0]  EXP_GLITCH = 8'h00;
`else
  localparam int          EXP_LAT    = 307;          // 9.5 * 32 + 3
  localparam logic [7:0]  EXP_GLITCH = 8'h04;
`endif

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
  rx_state_e     dbg_state;

  uart_rx #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (BAUD),
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  logic [DW-1:0] exp_q[$];
  int   valid_cnt = 0;
  int   fe_cnt = 0;
  int   both_cnt = 0;
  int   long_cnt = 0;
  int   last_valid_cyc = 0;
  int   fall_cyc = 0;
  logic busy_at_valid = 1'b1;
  logic prev_valid = 1'b0;
  logic start_seen = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      busy_at_valid  = busy;
      if (exp_q.size() > 0) check("sb_data", data_out, exp_q.pop_front());
    end
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both_cnt++;
    if (data_valid && prev_valid) long_cnt++;
    prev_valid = data_valid;
    if (dbg_state == START) start_seen = 1'b1;
  end

  // drivers (called on a falling clock edge)
  task automatic idle_clocks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int glitch_bit, input int stop_clks);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == glitch_bit) begin
        repeat (BIT / 2) @(negedge clk);
        rx = ~d[i];
        @(negedge clk);
        rx = d[i];
        repeat (BIT / 2 - 1) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    rx = stop_bit;
    repeat (stop_clks) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  int v0, f0;
  logic [7:0] pat;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    idle_clocks(5);

    // single frame
    v0 = valid_cnt; f0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, BIT);
    idle_clocks(4);
    check("a5_pulses", valid_cnt - v0, 1);
    check("a5_data", data_out, 8'hA5);
    check("a5_latency", last_valid_cyc - fall_cyc, EXP_LAT);
    check("a5_busy_at_valid", busy_at_valid, 1'b0);
    check("a5_no_frame_err", fe_cnt - f0, 0);
    check("a5_sb_drained", exp_q.size(), 0);

    // back-to-back frames, single stop bit between
    v0 = valid_cnt; f0 = fe_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, -1, BIT);
    send_frame(8'hFF, 1'b1, -1, BIT);
    idle_clocks(4);
    check("b2b_pulses", valid_cnt - v0, 2);
    check("b2b_no_frame_err", fe_cnt - f0, 0);
    check("b2b_sb_drained", exp_q.size(), 0);
    check("b2b_data_last", data_out, 8'hFF);

    // short low glitch on an idle line (10 clocks < half bit)
    v0 = valid_cnt; f0 = fe_cnt;
    start_seen = 1'b0;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    idle_clocks(2 * BIT);
    check("glitch_start_seen", start_seen, 1'b1);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_frame_err", fe_cnt - f0, 0);
    check("glitch_idle", busy, 1'b0);

    // framing error with the line held low for three bit times
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, BIT);
    idle_clocks(4);
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, 3 * BIT);
    check("brk_frame_err_once", fe_cnt - f0, 1);
    check("brk_no_valid", valid_cnt - v0, 0);
    check("brk_data_held", data_out, 8'hA5);
    check("brk_busy_held", busy, 1'b1);
    check("brk_state", dbg_state, BREAK);
    rx = 1'b1;
    wait_idle("brk_release");
    idle_clocks(4);
    v0 = valid_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, BIT);
    idle_clocks(4);
    check("after_brk_pulses", valid_cnt - v0, 1);
    check("after_brk_data", data_out, 8'h5A);
    check("after_brk_sb_drained", exp_q.size(), 0);

    // asynchronous reset during data bit 4
    v0 = valid_cnt;
    pat = 8'h55;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = pat[i];
      repeat (BIT) @(negedge clk);
    end
    rx = pat[4];
    repeat (BIT / 2) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data_out", data_out, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_state", dbg_state, IDLE);
    check("arst_valid", data_valid, 1'b0);
    check("arst_frame_err", frame_err, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_clocks(5);
    check("arst_no_pulse", valid_cnt - v0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, BIT);
    idle_clocks(4);
    check("arst_next_pulses", valid_cnt - v0, 1);
    check("arst_next_data", data_out, 8'h81);

    // one-clock high glitch at mid bit 2 of 0x00
    exp_q.push_back(EXP_GLITCH);
    send_frame(8'h00, 1'b1, 2, BIT);
    idle_clocks(4);
    check("midbit_glitch_data", data_out, EXP_GLITCH);
    check("midbit_sb_drained", exp_q.size(), 0);

    check("never_both_pulses", both_cnt, 0);
    check("valid_width_one", long_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
